mc_controller: RTL and testbench

Parametrised multicycle MIPS control unit that succeeds the split maindec/aludec controller. It holds the instruction-sequencing FSM and the ALU decode in one block. It adds BNE, J, ANDI and ORI support, a memory-ready stall handshake, an illegal-instruction flag and a state debug port. It sits between the instruction register (op and funct fields) and the multicycle datapath.

---
 rtl/mc_controller.sv | 183 ++++++++++++++++++
 tb/tb_mc_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control unit: sequencing FSM plus ALU decode
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EN_BNE        = 1'b1,
    parameter bit EN_IMM_LOGIC  = 1'b1,
    parameter bit EN_JUMP       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regdst,
    output logic       regwrite,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       iord,
    output logic       zext,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BREX    = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_LOGIEX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic       w_ready;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_irwrite;
    logic       w_illegal;

    assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_illegal  = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        regdst     = 1'b0;
        alucontrol = 3'b010;
        iord       = 1'b0;
        zext       = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
                w_next    = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW)                         w_next = S_MEMADR;
                else if (op == OP_RTYPE)                                w_next = S_RTYPEEX;
                else if (op == OP_BEQ || (EN_BNE && op == OP_BNE))      w_next = S_BREX;
                else if (op == OP_ADDI)                                 w_next = S_ADDIEX;
                else if (EN_IMM_LOGIC && (op == OP_ANDI || op == OP_ORI)) w_next = S_LOGIEX;
                else if (EN_JUMP && op == OP_J)                         w_next = S_JEX;
                else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = w_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_next  = S_RTYPEWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   w_illegal  = 1'b1;
                endcase
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BREX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_branch   = (op == OP_BEQ && zero) || (EN_BNE && op == OP_BNE && !zero);
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_IMMWB;
            end
            S_IMMWB: begin
                w_regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_LOGIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                zext       = 1'b1;
                alucontrol = (op == OP_ANDI) ? 3'b000 : 3'b001;
                w_next     = S_IMMWB;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Write enables and the illegal pulse are held off for the whole reset window.
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign irwrite  = w_irwrite & ~reset;
    assign pcen     = (w_pcwrite | w_branch) & ~reset;
    assign illegal  = w_illegal & ~reset;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed-vector bench for mc_controller
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;

    logic       a_memtoreg, a_memwrite, a_pcen, a_alusrca, a_regdst, a_regwrite;
    logic       a_irwrite, a_iord, a_zext, a_illegal;
    logic [1:0] a_pcsrc, a_alusrcb;
    logic [2:0] a_alucontrol;
    logic [3:0] a_state;

    logic       b_memtoreg, b_memwrite, b_pcen, b_alusrca, b_regdst, b_regwrite;
    logic       b_irwrite, b_iord, b_zext, b_illegal;
    logic [1:0] b_pcsrc, b_alusrcb;
    logic [2:0] b_alucontrol;
    logic [3:0] b_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memtoreg(a_memtoreg), .memwrite(a_memwrite), .pcen(a_pcen), .pcsrc(a_pcsrc),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .regdst(a_regdst), .regwrite(a_regwrite),
        .alucontrol(a_alucontrol), .irwrite(a_irwrite), .iord(a_iord), .zext(a_zext),
        .illegal(a_illegal), .state(a_state)
    );

    mc_controller #(.MEM_HANDSHAKE(1'b0), .EN_BNE(1'b0), .EN_IMM_LOGIC(1'b0), .EN_JUMP(1'b0)) dut_min (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memtoreg(b_memtoreg), .memwrite(b_memwrite), .pcen(b_pcen), .pcsrc(b_pcsrc),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .regdst(b_regdst), .regwrite(b_regwrite),
        .alucontrol(b_alucontrol), .irwrite(b_irwrite), .iord(b_iord), .zext(b_zext),
        .illegal(b_illegal), .state(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; op = 6'b100011; funct = 6'b100000; zero = 1'b0;
        tick();
        tick();
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", a_state); end
        n_vec++; if (a_irwrite !== 1'b0) begin n_err++; $display("FAIL reset_irwrite got %b exp 0", a_irwrite); end
        n_vec++; if (a_pcen !== 1'b0) begin n_err++; $display("FAIL reset_pcen got %b exp 0", a_pcen); end
        n_vec++; if (a_alucontrol !== 3'b010) begin n_err++; $display("FAIL reset_alucontrol got %b exp 010", a_alucontrol); end
        reset = 1'b0;
        #1;
        n_vec++; if (a_irwrite !== 1'b1) begin n_err++; $display("FAIL fetch_irwrite got %b exp 1", a_irwrite); end
    endtask

    task automatic test_lw();
        logic [3:0] exp_state [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (a_state !== exp_state[i]) begin n_err++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, a_state, exp_state[i]); end
            n_vec++; if (a_regwrite !== (i == 4)) begin n_err++; $display("FAIL lw_regwrite[%0d] got %b exp %b", i, a_regwrite, i == 4); end
            n_vec++; if (a_memtoreg !== (i == 4)) begin n_err++; $display("FAIL lw_memtoreg[%0d] got %b exp %b", i, a_memtoreg, i == 4); end
            n_vec++; if (a_pcen !== (i == 0)) begin n_err++; $display("FAIL lw_pcen[%0d] got %b exp %b", i, a_pcen, i == 0); end
            tick();
        end
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL lw_end_state got %0d exp 0", a_state); end
    endtask

    task automatic test_sw_stall();
        do_reset();
        op = 6'b101011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            n_vec++; if (a_state !== 4'd5) begin n_err++; $display("FAIL sw_state[%0d] got %0d exp 5", i, a_state); end
            n_vec++; if (a_memwrite !== 1'b1) begin n_err++; $display("FAIL sw_memwrite[%0d] got %b exp 1", i, a_memwrite); end
            n_vec++; if (a_iord !== 1'b1) begin n_err++; $display("FAIL sw_iord[%0d] got %b exp 1", i, a_iord); end
            tick();
        end
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL sw_end_state got %0d exp 0", a_state); end
        n_vec++; if (a_memwrite !== 1'b0) begin n_err++; $display("FAIL sw_end_memwrite got %b exp 0", a_memwrite); end
    endtask

    task automatic test_fetch_stall();
        do_reset();
        op = 6'b000000; funct = 6'b100000;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (a_irwrite !== 1'b0) begin n_err++; $display("FAIL stall_irwrite[%0d] got %b exp 0", i, a_irwrite); end
            n_vec++; if (a_pcen !== 1'b0) begin n_err++; $display("FAIL stall_pcen[%0d] got %b exp 0", i, a_pcen); end
            n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL stall_state[%0d] got %0d exp 0", i, a_state); end
            if (i == 0) begin
                n_vec++; if (b_pcen !== 1'b1) begin n_err++; $display("FAIL nohs_pcen got %b exp 1", b_pcen); end
            end
            tick();
            if (i == 0) begin
                n_vec++; if (b_state !== 4'd1) begin n_err++; $display("FAIL nohs_state got %0d exp 1", b_state); end
            end
        end
        mem_ready = 1'b1;
        #1;
        n_vec++; if (a_irwrite !== 1'b1) begin n_err++; $display("FAIL release_irwrite got %b exp 1", a_irwrite); end
        n_vec++; if (a_pcen !== 1'b1) begin n_err++; $display("FAIL release_pcen got %b exp 1", a_pcen); end
        tick();
        n_vec++; if (a_state !== 4'd1) begin n_err++; $display("FAIL release_state got %0d exp 1", a_state); end
        n_vec++; if (a_irwrite !== 1'b0 || a_pcen !== 1'b0) begin n_err++; $display("FAIL release_pulse got %b%b exp 00", a_irwrite, a_pcen); end
    endtask

    task automatic test_branch();
        logic [5:0] br_op [3]  = '{6'b000100, 6'b000101, 6'b000101};
        logic       br_z  [3]  = '{1'b1, 1'b1, 1'b0};
        logic       br_pc [3]  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            op = br_op[i]; zero = br_z[i];
            tick();
            #1;
            if (i == 1) begin
                n_vec++; if (b_illegal !== 1'b1) begin n_err++; $display("FAIL nobne_illegal got %b exp 1", b_illegal); end
            end
            tick();
            if (i == 1) begin
                n_vec++; if (b_state !== 4'd0) begin n_err++; $display("FAIL nobne_state got %0d exp 0", b_state); end
            end
            n_vec++; if (a_state !== 4'd8) begin n_err++; $display("FAIL br_state[%0d] got %0d exp 8", i, a_state); end
            n_vec++; if (a_pcen !== br_pc[i]) begin n_err++; $display("FAIL br_pcen[%0d] got %b exp %b", i, a_pcen, br_pc[i]); end
            n_vec++; if (a_pcsrc !== 2'b01 || a_alucontrol !== 3'b110) begin n_err++; $display("FAIL br_ctl[%0d] got %b/%b exp 01/110", i, a_pcsrc, a_alucontrol); end
            tick();
            n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL br_end[%0d] got %0d exp 0", i, a_state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_imm_jump();
        do_reset();
        op = 6'b001101;
        tick();
        #1;
        n_vec++; if (b_illegal !== 1'b1) begin n_err++; $display("FAIL noimm_illegal got %b exp 1", b_illegal); end
        tick();
        n_vec++; if (a_state !== 4'd12) begin n_err++; $display("FAIL ori_state got %0d exp 12", a_state); end
        n_vec++; if (a_zext !== 1'b1 || a_alucontrol !== 3'b001) begin n_err++; $display("FAIL ori_ex got zext=%b alu=%b exp 1/001", a_zext, a_alucontrol); end
        op = 6'b001100;
        #1;
        n_vec++; if (a_alucontrol !== 3'b000) begin n_err++; $display("FAIL andi_alu got %b exp 000", a_alucontrol); end
        tick();
        n_vec++; if (a_state !== 4'd10 || a_regdst !== 1'b0 || a_regwrite !== 1'b1) begin n_err++; $display("FAIL immwb got st=%0d rd=%b rw=%b exp 10/0/1", a_state, a_regdst, a_regwrite); end
        tick();
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL imm_end got %0d exp 0", a_state); end
        op = 6'b000010;
        tick(); tick();
        n_vec++; if (a_state !== 4'd11 || a_pcen !== 1'b1 || a_pcsrc !== 2'b10) begin n_err++; $display("FAIL jex got st=%0d pcen=%b pcsrc=%b exp 11/1/10", a_state, a_pcen, a_pcsrc); end
        tick();
        op = 6'b111111;
        tick();
        n_vec++; if (a_illegal !== 1'b1) begin n_err++; $display("FAIL badop_illegal got %b exp 1", a_illegal); end
        tick();
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL badop_state got %0d exp 0", a_state); end
    endtask

    task automatic test_rtype();
        do_reset();
        op = 6'b000000; funct = 6'b000000;
        tick(); tick();
        n_vec++; if (a_state !== 4'd6 || a_illegal !== 1'b1) begin n_err++; $display("FAIL badfunct got st=%0d ill=%b exp 6/1", a_state, a_illegal); end
        n_vec++; if (a_alucontrol !== 3'b010) begin n_err++; $display("FAIL badfunct_alu got %b exp 010", a_alucontrol); end
        funct = 6'b101010;
        #1;
        n_vec++; if (a_alucontrol !== 3'b111 || a_illegal !== 1'b0) begin n_err++; $display("FAIL slt got alu=%b ill=%b exp 111/0", a_alucontrol, a_illegal); end
        tick();
        n_vec++; if (a_state !== 4'd7 || a_regwrite !== 1'b1 || a_regdst !== 1'b1) begin n_err++; $display("FAIL rtypewb got st=%0d rw=%b rd=%b exp 7/1/1", a_state, a_regwrite, a_regdst); end
        tick();
        n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL rtype_end got %0d exp 0", a_state); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        op = 6'b000000; funct = 6'b100010;
        tick(); tick();
        reset = 1'b1;
        #1;
        n_vec++; if (a_regwrite !== 1'b0) begin n_err++; $display("FAIL midrst_regwrite got %b exp 0", a_regwrite); end
        tick();
        n_vec++; if (a_state !== 4'd0 || a_regwrite !== 1'b0) begin n_err++; $display("FAIL midrst_state got st=%0d rw=%b exp 0/0", a_state, a_regwrite); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_branch();
        test_imm_jump();
        test_rtype();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
